ex_md_stage: RTL



---
 rtl/ex_md_stage.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/ex_md_stage.sv
// ex_md_stage: RV32IM execute stage with forwarding, single-cycle multiplier, iterative divider and valid/ready handshake; `EX_MD_DIV_REUSE_EN adds a last-divide result cache
module ex_md_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    output logic            ready_o,
    output logic            valid_o,
    input  logic            ready_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [XLEN-1:0] imm_ext_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            alu_src_i,
    input  logic [3:0]      alu_op_i,
    input  logic            is_md_i,
    input  logic [2:0]      md_funct3_i,
    input  logic [2:0]      funct3_i,
    input  logic            is_branch_i,
    input  logic            is_jal_i,
    input  logic            is_jalr_i,
    input  logic [4:0]      rd_addr_i,
    input  logic [1:0]      fwd_a_sel_i,
    input  logic [1:0]      fwd_b_sel_i,
    input  logic [XLEN-1:0] ex_mem_result_i,
    input  logic [XLEN-1:0] mem_wb_result_i,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_addr_o,
    output logic            branch_taken_o,
    output logic [XLEN-1:0] branch_target_o,
    output logic            stall_o
);
    localparam int SH_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state;

    logic [XLEN-1:0] op_a, fwd_b, op_b, alu_res, mul_res, target, q_fin, r_fin, div_res;
    logic [XLEN-1:0] a_abs, b_abs, quo_q, rem_q, dvs_q, rq, rr;
    logic [2*XLEN-1:0] ma, mb, prod;
    logic [XLEN+1:0] diff;
    logic [CNT_W-1:0] cnt;
    logic [4:0] rd_q;
    logic cond, taken, cf, is_div, div_sgn, a_neg, b_neg, div_zero, div_ovf, accept, reuse_hit;
    logic ge, neg_q, neg_r, op_rem;

    assign op_a  = fwd_a_sel_i == 2'b01 ? ex_mem_result_i : fwd_a_sel_i == 2'b10 ? mem_wb_result_i : rs1_data_i;
    assign fwd_b = fwd_b_sel_i == 2'b01 ? ex_mem_result_i : fwd_b_sel_i == 2'b10 ? mem_wb_result_i : rs2_data_i;
    assign op_b  = alu_src_i ? imm_ext_i : fwd_b;

    // integer ALU
    always_comb begin
        alu_res = op_a + op_b;
        case (alu_op_i)
            4'd1:    alu_res = op_a - op_b;
            4'd2:    alu_res = op_a << op_b[SH_W-1:0];
            4'd3:    alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            4'd4:    alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            4'd5:    alu_res = op_a ^ op_b;
            4'd6:    alu_res = op_a >> op_b[SH_W-1:0];
            4'd7:    alu_res = $signed(op_a) >>> op_b[SH_W-1:0];
            4'd8:    alu_res = op_a | op_b;
            4'd9:    alu_res = op_a & op_b;
            4'd10:   alu_res = op_b;
            default: alu_res = op_a + op_b;
        endcase
    end

    // sign/zero extension to 2*XLEN makes one truncated product serve all four MUL variants
    assign ma      = {{XLEN{op_a[XLEN-1] & (md_funct3_i[1:0] != 2'b11)}}, op_a};
    assign mb      = {{XLEN{fwd_b[XLEN-1] & (md_funct3_i[1:0] == 2'b01)}}, fwd_b};
    assign prod    = ma * mb;
    assign mul_res = md_funct3_i[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    // branch condition and target
    always_comb begin
        cond = 1'b0;
        case (funct3_i)
            3'd0:    cond = op_a == fwd_b;
            3'd1:    cond = op_a != fwd_b;
            3'd4:    cond = $signed(op_a) < $signed(fwd_b);
            3'd5:    cond = $signed(op_a) >= $signed(fwd_b);
            3'd6:    cond = op_a < fwd_b;
            3'd7:    cond = op_a >= fwd_b;
            default: cond = 1'b0;
        endcase
    end

    assign cf     = is_branch_i | is_jal_i | is_jalr_i;
    assign taken  = is_jal_i | is_jalr_i | (is_branch_i & cond);
    assign target = is_jalr_i ? (op_a + imm_ext_i) & {{(XLEN-1){1'b1}}, 1'b0} : pc_i + imm_ext_i;

    assign is_div   = is_md_i & md_funct3_i[2];
    assign div_sgn  = ~md_funct3_i[0];
    assign a_neg    = div_sgn & op_a[XLEN-1];
    assign b_neg    = div_sgn & fwd_b[XLEN-1];
    assign a_abs    = a_neg ? -op_a : op_a;
    assign b_abs    = b_neg ? -fwd_b : fwd_b;
    assign div_zero = fwd_b == '0;
    assign div_ovf  = div_sgn & (op_a == MIN) & (&fwd_b);
    assign accept   = state == IDLE & valid_i & is_div & ~flush_i;

    // restoring step: partial remainder is one bit wider than XLEN to cover unsigned divisors
    assign diff  = {1'b0, rem_q, quo_q[XLEN-1]} - {2'b00, dvs_q};
    assign ge    = ~diff[XLEN+1];
    assign q_fin = neg_q ? -quo_q : quo_q;
    assign r_fin = neg_r ? -rem_q : rem_q;
    assign div_res = op_rem ? r_fin : q_fin;

`ifdef EX_MD_DIV_REUSE_EN
    logic rv, rs_s, pend_s;
    logic [XLEN-1:0] ra, rb, pend_a, pend_b;
    assign reuse_hit = rv & (rs_s == div_sgn) & (ra == op_a) & (rb == fwd_b);

    // remember the operands of the divide in flight and cache its result once it is handed off
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rv <= 1'b0; rs_s <= 1'b0; pend_s <= 1'b0;
            ra <= '0; rb <= '0; rq <= '0; rr <= '0; pend_a <= '0; pend_b <= '0;
        end else begin
            if (accept) begin
                pend_a <= op_a;
                pend_b <= fwd_b;
                pend_s <= div_sgn;
            end
            if (state == BUSY && flush_i) rv <= 1'b0;
            else if (state == DONE && ready_i && !flush_i) begin
                rv <= 1'b1; rs_s <= pend_s; ra <= pend_a; rb <= pend_b; rq <= q_fin; rr <= r_fin;
            end
        end
    end
`else
    assign reuse_hit = 1'b0;
    assign rq = '0;
    assign rr = '0;
`endif

    // divider FSM: special cases and cache hits load final values and go straight to DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE; cnt <= '0; quo_q <= '0; rem_q <= '0; dvs_q <= '0;
            neg_q <= 1'b0; neg_r <= 1'b0; op_rem <= 1'b0; rd_q <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op_rem <= md_funct3_i[1];
                    rd_q   <= rd_addr_i;
                    cnt    <= CNT_W'(XLEN);
                    dvs_q  <= b_abs;
                    neg_q  <= 1'b0;
                    neg_r  <= 1'b0;
                    state  <= DONE;
                    if (div_zero) begin
                        quo_q <= '1; rem_q <= op_a;
                    end else if (div_ovf) begin
                        quo_q <= MIN; rem_q <= '0;
                    end else if (reuse_hit) begin
                        quo_q <= rq; rem_q <= rr;
                    end else begin
                        quo_q <= a_abs; rem_q <= '0;
                        neg_q <= a_neg ^ b_neg; neg_r <= a_neg;
                        state <= BUSY;
                    end
                end
                BUSY: if (flush_i) state <= IDLE;
                else begin
                    rem_q <= ge ? diff[XLEN-1:0] : {rem_q[XLEN-2:0], quo_q[XLEN-1]};
                    quo_q <= {quo_q[XLEN-2:0], ge};
                    cnt   <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) state <= DONE;
                end
                DONE: if (flush_i || ready_i) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // handshake and result presentation; everything reads zero while valid_o is low
    always_comb begin
        valid_o         = state == IDLE ? valid_i & ~flush_i & ~is_div : state == DONE & ~flush_i;
        ready_o         = state == IDLE ? is_div | ready_i : 1'b0;
        stall_o         = state != IDLE;
        result_o        = !valid_o ? '0 : state == DONE ? div_res : is_md_i ? mul_res :
                          (is_jal_i | is_jalr_i) ? pc_i + XLEN'(4) : alu_res;
        rd_addr_o       = !valid_o ? '0 : state == DONE ? rd_q : rd_addr_i;
        branch_taken_o  = valid_o & state == IDLE & taken;
        branch_target_o = valid_o & state == IDLE & cf ? target : '0;
    end
endmodule
